// File: rtl/debounce_event_bank.sv
// Multi-channel button/switch debouncer: sync, optional inversion, stable-time filter,
// rise/fall pulses and wrapping press counters. Define DEBOUNCE_AUTOREPEAT_EN for hold auto-repeat.
module debounce_event_bank #(
  parameter int                  CHANNELS      = 4,
  parameter int                  STABLE_CYCLES = 101,
  parameter int                  PRESS_W       = 8,
  parameter logic [CHANNELS-1:0] INVERT_MASK   = '0,
  parameter int                  REPEAT_DELAY  = 25000000,
  parameter int                  REPEAT_PERIOD = 5000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS-1:0]         btn_in,
  input  logic                        clr_counts,
  output logic [CHANNELS-1:0]         level,
  output logic [CHANNELS-1:0]         rise,
  output logic [CHANNELS-1:0]         fall,
  output logic [CHANNELS*PRESS_W-1:0] press_count,
  output logic                        any_event
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (CHANNELS < 1 || STABLE_CYCLES < 1 || PRESS_W < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_err
    $error("debounce_event_bank: invalid parameter value");
  end

  logic [CHANNELS-1:0] r_sync_p0;
  logic [CHANNELS-1:0] r_sync_p1;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic                r_any;
  logic [CHANNELS-1:0] w_rise_nxt;
  logic [CHANNELS-1:0] w_fall_nxt;

  // Stage p0/p1: two-flop synchroniser on the (optionally inverted) raw pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= btn_in ^ INVERT_MASK;
      r_sync_p1 <= r_sync_p0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0]   r_cnt;
    logic               r_lvl;
    logic [PRESS_W-1:0] r_pc;
    logic               w_diff;
    logic               w_acc;
    logic               w_rep;

    assign w_diff = r_sync_p1[g] ^ r_lvl;
    assign w_acc  = w_diff && (r_cnt == CNT_LAST);

    // Stage p2: stable-time filter; any sample matching the level restarts qualification
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_acc) begin
        r_cnt <= '0;
        r_lvl <= r_sync_p1[g];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] DLY_LAST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PER_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_rep_phase;

    // A pending fall acceptance takes priority over a repeat on the same edge
    assign w_rep = r_lvl && !w_acc && (r_hold == (r_rep_phase ? PER_LAST : DLY_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hold      <= '0;
        r_rep_phase <= 1'b0;
      end else if (w_acc || !r_lvl) begin
        r_hold      <= '0;
        r_rep_phase <= 1'b0;
      end else if (w_rep) begin
        r_hold      <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
`else
    assign w_rep = 1'b0;
`endif

    assign w_rise_nxt[g] = (w_acc & r_sync_p1[g]) | w_rep;
    assign w_fall_nxt[g] = w_acc & ~r_sync_p1[g];

    // Counter follows the registered rise, so a clear in the pulse cycle wins
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pc <= '0;
      end else if (clr_counts) begin
        r_pc <= '0;
      end else if (r_rise[g]) begin
        r_pc <= r_pc + 1'b1;
      end
    end

    assign level[g]                          = r_lvl;
    assign press_count[g*PRESS_W +: PRESS_W] = r_pc;
  end

  // Stage p3: registered event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= '0;
      r_fall <= '0;
      r_any  <= 1'b0;
    end else begin
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
      r_any  <= |(w_rise_nxt | w_fall_nxt);
    end
  end

  assign rise      = r_rise;
  assign fall      = r_fall;
  assign any_event = r_any;

endmodule

// File: tb/tb_debounce_event_bank.sv
// Self-checking bench for debounce_event_bank: directed scenarios plus randomized bouncing
// compared every cycle against a run-length reference model.
module tb_debounce_event_bank;

  localparam int CH = 4;
  localparam int SC = 4;
  localparam int PW = 8;
  localparam logic [CH-1:0] MASK = 4'b0001;
  localparam int RD = 20;
  localparam int RP = 10;
`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam bit AR_EN = 1'b1;
  localparam int EXP_HOLD_RISES = 5;
`else
  localparam bit AR_EN = 1'b0;
  localparam int EXP_HOLD_RISES = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic [CH-1:0]    btn_in;
  logic             clr_counts;
  logic [CH-1:0]    level;
  logic [CH-1:0]    rise;
  logic [CH-1:0]    fall;
  logic [CH*PW-1:0] press_count;
  logic             any_event;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  debounce_event_bank #(
    .CHANNELS(CH), .STABLE_CYCLES(SC), .PRESS_W(PW), .INVERT_MASK(MASK),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .clr_counts(clr_counts),
    .level(level), .rise(rise), .fall(fall), .press_count(press_count),
    .any_event(any_event)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a new level is taken once SC consecutive synchronised samples disagree with it.
  logic [CH-1:0] m_d1    = '0;
  logic [CH-1:0] m_d2    = '0;
  logic [CH-1:0] m_level = '0;
  logic [CH-1:0] m_rise  = '0;
  logic [CH-1:0] m_fall  = '0;
  int m_run [CH] = '{default: 0};
  int m_age [CH] = '{default: 0};
  int m_cnt [CH] = '{default: 0};

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
      for (int c = 0; c < CH; c++) begin
        m_run[c] = 0; m_age[c] = 0; m_cnt[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        bit nr, nf;
        nr = 1'b0; nf = 1'b0;
        if (clr_counts) m_cnt[c] = 0;
        else if (m_rise[c]) m_cnt[c] = (m_cnt[c] + 1) % (1 << PW);
        if (m_d2[c] != m_level[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == SC) begin
          m_level[c] = m_d2[c];
          m_run[c]   = 0;
          m_age[c]   = 0;
          nr = m_level[c];
          nf = !m_level[c];
        end else if (m_level[c]) begin
          m_age[c]++;
          if (AR_EN && m_age[c] >= RD && ((m_age[c] - RD) % RP) == 0) nr = 1'b1;
        end else begin
          m_age[c] = 0;
        end
        m_rise[c] = nr;
        m_fall[c] = nf;
      end
      m_d2 = m_d1;
      m_d1 = btn_in ^ MASK;
    end
  end

  int rise_seen [CH] = '{default: 0};
  int fall_seen [CH] = '{default: 0};

  initial forever begin
    logic [CH*PW-1:0] exp_pc;
    @(posedge clk);
    #1;
    if (mon_en) begin
      exp_pc = '0;
      for (int c = 0; c < CH; c++) exp_pc[c*PW +: PW] = m_cnt[c][PW-1:0];
      chk("level", level, m_level);
      chk("rise", rise, m_rise);
      chk("fall", fall, m_fall);
      chk("any_event", any_event, |(m_rise | m_fall));
      chk("press_count", press_count, exp_pc);
      chk("rise_fall_excl", rise & fall, 0);
      for (int c = 0; c < CH; c++) begin
        rise_seen[c] += int'(rise[c]);
        fall_seen[c] += int'(fall[c]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, f0;
    rst_n = 1'b0; btn_in = 4'b1111; clr_counts = 1'b0;
    cyc(2);
    mon_en = 1'b1;
    cyc(2);
    chk("rst_level", level, 0);
    chk("rst_count", press_count, 0);

    // Release with all pins asserted: ch0 is inverted so stays released
    rst_n = 1'b1;
    cyc(5);
    chk("rel_level_early", level, 4'b0000);
    cyc(1);
    chk("rel_level", level, 4'b1110);
    chk("rel_rise", rise, 4'b1110);
    cyc(1);
    chk("rel_rise_once", rise, 4'b0000);
    chk("rel_count", press_count, 32'h0101_0100);

    // Bounce on ch2 shorter than the stable time
    btn_in = 4'b0001;
    cyc(10);
    r0 = rise_seen[2];
    for (int k = 0; k < 20; k++) begin
      btn_in[2] = ~btn_in[2];
      cyc(2);
    end
    chk("bounce_norise", rise_seen[2] - r0, 0);
    btn_in[2] = 1'b1;
    cyc(5);
    chk("bounce_early", rise_seen[2] - r0, 0);
    cyc(1);
    chk("bounce_rise", rise[2], 1);
    cyc(1);
    chk("bounce_count", press_count[23:16], 8'd2);
    btn_in[2] = 1'b0;
    cyc(10);

    // 256 clean presses wrap an 8-bit counter
    clr_counts = 1'b1; cyc(1); clr_counts = 1'b0;
    r0 = rise_seen[1]; f0 = fall_seen[1];
    for (int k = 0; k < 256; k++) begin
      btn_in[1] = 1'b1; cyc(8);
      btn_in[1] = 1'b0; cyc(8);
    end
    chk("wrap_count", press_count[15:8], 0);
    chk("wrap_rises", rise_seen[1] - r0, 256);
    chk("wrap_falls", fall_seen[1] - f0, 256);

    // Clear in the same cycle as a rise on ch3
    clr_counts = 1'b1; cyc(1); clr_counts = 1'b0;
    for (int k = 0; k < 5; k++) begin
      btn_in[3] = 1'b1; cyc(8);
      btn_in[3] = 1'b0; cyc(8);
    end
    btn_in[3] = 1'b1;
    cyc(6);
    chk("coll_rise", rise[3], 1);
    chk("coll_pre", press_count[31:24], 5);
    clr_counts = 1'b1; cyc(1); clr_counts = 1'b0;
    chk("coll_count", press_count[31:24], 0);
    chk("coll_level", level[3], 1);
    cyc(4);
    chk("coll_count_hold", press_count[31:24], 0);

    // Long hold on ch2
    r0 = rise_seen[2];
    btn_in[2] = 1'b1;
    cyc(6);
    chk("hold_first", rise[2], 1);
    cyc(50);
    chk("hold_rises", rise_seen[2] - r0, EXP_HOLD_RISES);
    f0 = fall_seen[2];
    btn_in[2] = 1'b0;
    cyc(10);
    chk("hold_fall", fall_seen[2] - f0, 1);

    // Reset in the middle of a pending ch1 press; ch3 is held high
    btn_in[1] = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk("async_level", level, 0);
    chk("async_count", press_count, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk("midrst_early", level, 4'b0000);
    cyc(1);
    chk("midrst_level", level, 4'b1010);

    // Randomized bouncing, clears and occasional resets
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 6) == 0) btn_in[c] = ~btn_in[c];
      clr_counts = ($urandom_range(0, 49) == 0);
      rst_n      = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    clr_counts = 1'b0;
    rst_n = 1'b1;
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_event_bank.md
Name: debounce_event_bank

Overview:
- Parametrised multi-channel debouncer and edge-event generator for buttons and switches.
- Each channel has a 2-flop synchroniser, per-channel input inversion, a stable-time filter, and one-cycle rise/fall pulses.
- Each channel also has a wrapping press counter.
- Sits between board pins and control logic; a rise pulse can directly trigger sensor sample starts; press counts can drive LEDs.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- STABLE_CYCLES, 101: consecutive synchronised samples a new value must hold before it is accepted (>=1).
- PRESS_W, 8: width of each channel's press counter.
- INVERT_MASK, 0: CHANNELS-bit mask; a set bit inverts that raw input before synchronisation (active-low buttons).
- REPEAT_DELAY, 25000000: cycles held before the first auto-repeat pulse (optional feature only).
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat pulses (optional feature only).

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- btn_in  in  CHANNELS  raw asynchronous inputs.
- clr_counts  in  1  synchronous clear of all press counters.
- level  out  CHANNELS  debounced level, post-inversion; 1 = pressed.
- rise  out  CHANNELS  one-cycle pulse when level goes 0->1.
- fall  out  CHANNELS  one-cycle pulse when level goes 1->0.
- press_count  out  CHANNELS*PRESS_W  per-channel counters; channel i occupies bits [i*PRESS_W +: PRESS_W].
- any_event  out  1  OR of all rise and fall bits, same cycle.

Behaviour:
- Reset is asynchronous, rst_n low:
  - sync flops = 0, level = 0, rise = 0, fall = 0, press_count = 0, filter counters = 0.
  - Reset is asserted asynchronously and released synchronously to clk; the first active edge is the one after rst_n rises.
- Per channel, s = sync2 of (btn_in XOR INVERT_MASK bit).
- Filter state per channel: STABLE (s == level) or PENDING (s != level).
  - STABLE: counter held at 0.
  - PENDING: counter increments each cycle.
  - When counter == STABLE_CYCLES-1 and s != level:
    - level <= s and counter <= 0;
    - rise or fall is set for exactly that one cycle.
  - If s returns to level at any point before acceptance, counter <= 0. Any single-cycle glitch restarts the count.
- Filter counter width is clog2(STABLE_CYCLES+1). The counter never exceeds STABLE_CYCLES-1.
- Latency: let edge 0 be the first edge sampling the new pin value. level, and the matching rise or fall, change after edge STABLE_CYCLES+1, i.e. visible STABLE_CYCLES+2 cycles from the pin change.
- rise, fall and any_event are registered and high for one cycle only. rise and fall are never both set on one channel.
- Press counter:
  - increments on each rise;
  - wraps 2^PRESS_W-1 -> 0 silently.
- clr_counts:
  - zeroes all counters on the next edge;
  - if a rise occurs in the same cycle, clear wins and the result is 0;
  - clr_counts does not affect level or the filters.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Reset mid-PENDING: the pending change is discarded, and after release the filter re-qualifies from level = 0.

Optional Feature:
- Macro DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - each channel has a hold counter that starts at the rise;
  - while level stays 1, extra rise pulses are emitted REPEAT_DELAY cycles after the original rise, then every REPEAT_PERIOD cycles;
  - each repeat pulse also increments press_count and asserts any_event;
  - fall or reset clears the hold counter.
- Undefined: exactly one rise per press; no hold counters are synthesised.

Test Plan:
- Use STABLE_CYCLES=4, CHANNELS=4, INVERT_MASK=4'b0001.
- Reset: hold rst_n low with btn_in=4'b1111 -> level=4'b1110 only after release plus 6 cycles; rise=4'b1110 pulses once; press_count ch1..3=1, ch0=0.
- Bounce: ch2 toggles every 2 cycles for 40 cycles, then holds 1 -> no rise during toggling; one rise exactly 6 cycles after the final change; ch2 count +1.
- Wrap: PRESS_W=8, 256 clean presses on ch1 -> press_count ch1 = 0; 256 rise and 256 fall pulses observed.
- Clear collision: assert clr_counts on the exact cycle ch3 rise fires, with count at 5 -> count=0 next cycle; level ch3 stays 1.
- Reset mid-PENDING: ch1 driven high, rst_n pulsed low at cycle 3 of pending -> no rise until 6 cycles after release; level async-cleared during reset.
- With DEBOUNCE_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10: hold ch2 for 50 cycles after rise -> rise pulses at +0, +20, +30, +40, +50; count +5; release -> single fall.
